// File: rtl/ascii_pkg.sv
// Shared geometry, widths and helpers for the double-buffered ASCII character map.
package ascii_pkg;

    localparam int TILE_W = 16;
    localparam int TILE_H = 16;
    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 4;
    localparam int PIX_W  = 12;

    localparam int MAP_DEPTH   = COLS * ROWS;
    localparam int MAP_AW      = $clog2(MAP_DEPTH);
    localparam int RAM_AW      = MAP_AW + 1;
    localparam int TILE_W_LOG2 = $clog2(TILE_W);
    localparam int TILE_H_LOG2 = $clog2(TILE_H);

    localparam logic [PIX_W-1:0] SCREEN_W_PIX = PIX_W'(COLS * TILE_W);
    localparam logic [PIX_W-1:0] SCREEN_H_PIX = PIX_W'(ROWS * TILE_H);

    typedef logic [MAP_AW-1:0] map_addr_t;
    typedef logic [RAM_AW-1:0] ram_addr_t;
    typedef logic [CHAR_W-1:0] glyph_t;

    // Shifts plus a constant multiply by COLS; out-of-screen results are masked by the caller.
    function automatic map_addr_t tile_index(input logic [PIX_W-1:0] row,
                                             input logic [PIX_W-1:0] col);
        int unsigned idx;
        idx = int'(row >> TILE_H_LOG2) * COLS + int'(col >> TILE_W_LOG2);
        return map_addr_t'(idx);
    endfunction

    function automatic glyph_t tile_diag(input logic [PIX_W-1:0] row,
                                         input logic [PIX_W-1:0] col);
        logic [PIX_W-1:0] sum;
        sum = (row >> TILE_H_LOG2) + (col >> TILE_W_LOG2);
        return glyph_t'(sum);
    endfunction

endpackage

// File: rtl/ascii_char_map_if.sv
// Tile write, pixel lookup and status signals between the averaging stage, the map and print_char.
interface ascii_char_map_if;
    import ascii_pkg::*;

    logic             tile_valid;
    glyph_t           tile_char;
    logic             frame_start;
    logic             video_on;
    logic [PIX_W-1:0] pixel_row;
    logic [PIX_W-1:0] pixel_column;
    logic             test_pat;
    glyph_t           char_sel;
    logic             char_valid;
    logic             bank_sel;
    logic             wr_overflow;

    modport master (
        output tile_valid, tile_char, frame_start,
        output video_on, pixel_row, pixel_column, test_pat,
        input  char_sel, char_valid, bank_sel, wr_overflow
    );

    modport slave (
        input  tile_valid, tile_char, frame_start,
        input  video_on, pixel_row, pixel_column, test_pat,
        output char_sel, char_valid, bank_sel, wr_overflow
    );

endinterface

// File: rtl/char_map_dpram.sv
// Simple dual-port glyph RAM: one write port, one registered read port, bank bit as address MSB.
module char_map_dpram
    import ascii_pkg::*;
(
    input  logic      vga_clk,
    input  logic      wr_en,
    input  ram_addr_t wr_addr,
    input  glyph_t    wr_data,
    input  ram_addr_t rd_addr,
    output glyph_t    rd_data
);

    // Bank bit on the MSB keeps decoding trivial; the top of each half is never addressed.
    glyph_t mem [0:(1 << RAM_AW)-1];

    always_ff @(posedge vga_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ascii_char_map.sv
// Double-buffered glyph map: tiles fill the back bank while print_char reads the front bank.
// Defining ASCII_MAP_TESTPAT_EN adds a diagonal test pattern selected by test_pat.
module ascii_char_map
    import ascii_pkg::*;
(
    input logic             vga_clk,
    input logic             rst_n,
    ascii_char_map_if.slave bus
);

    map_addr_t wr_ptr;
    map_addr_t base_ptr;
    map_addr_t ptr_next;
    logic      back_full;
    logic      base_full;
    logic      full_next;
    logic      bank_sel_q;
    logic      bank_next;
    logic      swap;
    logic      front_ok;
    logic      wr_overflow_q;
    logic      wr_en;
    ram_addr_t wr_addr;

    ram_addr_t rd_addr_d1;
    logic      in_range_d1;
    logic      video_on_d1;
    logic      front_ok_d1;
    logic      show_d1;
    logic      char_valid_q;
    glyph_t    ram_q;

    // frame_start is resolved before a coincident tile, so that tile lands at index 0 of the new back bank.
    always_comb begin
        swap      = bus.frame_start & back_full;
        bank_next = bank_sel_q ^ swap;
        base_ptr  = bus.frame_start ? '0 : wr_ptr;
        base_full = bus.frame_start ? 1'b0 : back_full;
        wr_en     = bus.tile_valid & ~base_full;
        ptr_next  = base_ptr;
        full_next = base_full;
        if (wr_en) begin
            if (base_ptr == map_addr_t'(MAP_DEPTH - 1)) begin
                full_next = 1'b1;
            end else begin
                ptr_next = base_ptr + 1'b1;
            end
        end
    end

    assign wr_addr = {~bank_next, base_ptr};

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            back_full     <= 1'b0;
            bank_sel_q    <= 1'b0;
            front_ok      <= 1'b0;
            wr_overflow_q <= 1'b0;
        end else begin
            wr_ptr     <= ptr_next;
            back_full  <= full_next;
            bank_sel_q <= bank_next;
            if (swap) begin
                front_ok <= 1'b1;
            end
            if (bus.tile_valid & base_full) begin
                wr_overflow_q <= 1'b1;
            end
        end
    end

    char_map_dpram u_ram (
        .vga_clk (vga_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.tile_char),
        .rd_addr (rd_addr_d1),
        .rd_data (ram_q)
    );

    // The registered bank_sel is used here, so a swap reaches only pixels entering S1 afterwards.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_d1   <= '0;
            in_range_d1  <= 1'b0;
            video_on_d1  <= 1'b0;
            front_ok_d1  <= 1'b0;
            char_valid_q <= 1'b0;
        end else begin
            rd_addr_d1   <= {bank_sel_q, tile_index(bus.pixel_row, bus.pixel_column)};
            in_range_d1  <= (bus.pixel_row < SCREEN_H_PIX) && (bus.pixel_column < SCREEN_W_PIX);
            video_on_d1  <= bus.video_on;
            front_ok_d1  <= front_ok;
            char_valid_q <= video_on_d1 & in_range_d1 & show_d1;
        end
    end

`ifdef ASCII_MAP_TESTPAT_EN
    logic   tp_d1;
    logic   tp_d2;
    glyph_t tp_glyph_d1;
    glyph_t tp_glyph_d2;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_d1       <= 1'b0;
            tp_d2       <= 1'b0;
            tp_glyph_d1 <= '0;
            tp_glyph_d2 <= '0;
        end else begin
            tp_d1       <= bus.test_pat;
            tp_d2       <= tp_d1;
            tp_glyph_d1 <= tile_diag(bus.pixel_row, bus.pixel_column);
            tp_glyph_d2 <= tp_glyph_d1;
        end
    end

    assign show_d1      = front_ok_d1 | tp_d1;
    assign bus.char_sel = char_valid_q ? (tp_d2 ? tp_glyph_d2 : ram_q) : '0;
`else
    logic unused_test_pat;

    assign unused_test_pat = bus.test_pat;
    assign show_d1         = front_ok_d1;
    assign bus.char_sel    = char_valid_q ? ram_q : '0;
`endif

    assign bus.char_valid  = char_valid_q;
    assign bus.bank_sel    = bank_sel_q;
    assign bus.wr_overflow = wr_overflow_q;

endmodule
